// File: rtl/rr_burst_mux_pkg.sv
// mux_pkg: shared types and helpers for rr_burst_mux and its arbiter.
//   state_t     - arbitration state (ARB: free arbitration, BURST: grant locked)
//   clog2_min1  - index width for n channels, never narrower than 1 bit
//   PIX_DATA_W  - default payload width for packed pixel plot beats
package mux_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Packed pixel beat: 3-bit x cell, 3-bit y cell, 2-bit colour code.
    localparam int PIX_X_W      = 3;
    localparam int PIX_Y_W      = 3;
    localparam int PIX_COLOUR_W = 2;
    localparam int PIX_DATA_W   = PIX_X_W + PIX_Y_W + PIX_COLOUR_W;

endpackage

// File: rtl/rr_burst_mux_if.sv
// rr_burst_mux_if: handshake bundle between the draw sources and the plot port.
//   in_data/in_valid/in_last  sources -> mux (channel i at [i*DATA_W +: DATA_W])
//   in_ready                  mux -> sources, one-hot accept
//   out_data/out_src/out_last/out_valid  mux -> plot port
//   out_ready                 plot port -> mux
// Modports: master = source/sink side (bench), slave = the mux.
interface rr_burst_mux_if import mux_pkg::*; #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = PIX_DATA_W,
    parameter int SEL_W  = clog2_min1(NUM_CH)
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_last;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_src;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_src, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_src, out_last, out_valid
    );
endinterface

// File: rtl/rr_burst_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i     - request vector
//   rr_ptr_i  - last served channel; search starts at rr_ptr_i+1 and wraps
//   grant_o   - one-hot grant (all zero when no request)
//   idx_o     - index of the granted channel (0 when no request)
// Holding rr_ptr_i at NUM_CH-1 turns it into a lowest-index-wins priority encoder.
module rr_arbiter import mux_pkg::*; #(
    parameter  int NUM_CH = 3,
    localparam int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  rr_ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [SEL_W-1:0]  idx_o
);

    always_comb begin
        logic [SEL_W-1:0] ch;
        logic             found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        ch      = rr_ptr_i;
        for (int k = 0; k < NUM_CH; k++) begin
            // Explicit wrap so non-power-of-two channel counts work.
            ch = (ch == SEL_W'(NUM_CH - 1)) ? '0 : ch + SEL_W'(1);
            if (!found && req_i[ch]) begin
                found       = 1'b1;
                grant_o[ch] = 1'b1;
                idx_o       = ch;
            end
        end
    end

endmodule

// File: rtl/rr_burst_mux.sv
// rr_burst_mux: N-channel registered mux with round-robin arbitration and
// burst locking (a source keeps the grant from its first beat to in_last).
//   clock  - system clock
//   reset  - synchronous, active-high
//   bus    - rr_burst_mux_if.slave: inputs in_data/in_valid/in_last/out_ready,
//            outputs in_ready (combinational), out_data/out_src/out_last/out_valid
// Build option RR_BURST_MUX_FIXED_PRI_EN: free arbitration becomes fixed
// priority (lowest index wins) and the round-robin pointer is not built.
//
// state | meaning
// ARB   | no lock; grant picked by the arbiter each cycle
// BURST | lock_q owns the output until it sends a beat with in_last
module rr_burst_mux import mux_pkg::*; #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = PIX_DATA_W,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input logic           clock,
    input logic           reset,
    rr_burst_mux_if.slave bus
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  lock_q, lock_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [SEL_W-1:0]  arb_idx;
    logic [SEL_W-1:0]  arb_ptr;
    logic [SEL_W-1:0]  g;
    logic              g_valid;
    logic [DATA_W-1:0] g_data;
    logic              g_last;
    logic              accept;
    logic              take;

`ifdef RR_BURST_MUX_FIXED_PRI_EN
    assign arb_ptr = SEL_W'(NUM_CH - 1);
`else
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    assign arb_ptr = rr_ptr_q;
`endif

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i    (bus.in_valid),
        .rr_ptr_i (arb_ptr),
        .grant_o  (arb_grant),
        .idx_o    (arb_idx)
    );

    // Grant selection and input-side handshake.
    always_comb begin
        accept = !out_valid_q || bus.out_ready;
        if (state_q == BURST) begin
            g       = lock_q;
            g_valid = bus.in_valid[lock_q];
        end else begin
            g       = arb_idx;
            g_valid = |arb_grant;
        end
        take   = accept && g_valid;
        g_data = '0;
        g_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (g == SEL_W'(i)) begin
                g_data = bus.in_data[i*DATA_W +: DATA_W];
                g_last = bus.in_last[i];
            end
        end
        bus.in_ready = '0;
        if (take) begin
            bus.in_ready[g] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
`ifndef RR_BURST_MUX_FIXED_PRI_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        if (take) begin
            out_data_d  = g_data;
            out_src_d   = g;
            out_last_d  = g_last;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ARB: begin
                if (take && !g_last) begin
                    lock_d  = g;
                    state_d = BURST;
                end
`ifndef RR_BURST_MUX_FIXED_PRI_EN
                if (take && g_last) begin
                    rr_ptr_d = g;
                end
`endif
            end
            BURST: begin
                if (take && g_last) begin
                    state_d = ARB;
`ifndef RR_BURST_MUX_FIXED_PRI_EN
                    rr_ptr_d = lock_q;
`endif
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB;
            lock_q      <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifndef RR_BURST_MUX_FIXED_PRI_EN
            // Channel 0 gets first priority out of reset.
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
`endif
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
`ifndef RR_BURST_MUX_FIXED_PRI_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_burst_mux.sv
// Self-checking bench for rr_burst_mux: each source owns a queue of beats;
// a behavioural model predicts grants/in_ready and pushes expected output
// beats into a scoreboard that a separate monitor drains on each handshake.
module tb_rr_burst_mux;
    import mux_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int SEL_W  = clog2_min1(NUM_CH);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rr_burst_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    rr_burst_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  src;
        logic              last;
    } beat_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W:0] srcq [NUM_CH][$];   // {last, data} per source
    beat_t           expq [$];

    // Model state: last served channel, locked channel (-1 none), output slot full.
    int m_ptr;
    int m_lock;
    bit m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [NUM_CH-1:0] v, input int i);
        logic [NUM_CH-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int model_grant(input logic [NUM_CH-1:0] v);
        if (m_lock >= 0) return bit_of(v, m_lock) ? m_lock : -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (bit_of(v, (m_ptr + k) % NUM_CH)) return (m_ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = NUM_CH - 1;
        m_lock = -1;
        m_ov   = 1'b0;
    endtask

    task automatic add_beat(input int ch, input logic [DATA_W-1:0] d, input bit last);
        srcq[ch].push_back({last, d});
    endtask

    task automatic add_burst(input int ch, input int len, input logic [DATA_W-1:0] base);
        for (int b = 0; b < len; b++) add_beat(ch, base + DATA_W'(b), b == len - 1);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NUM_CH; i++) s += srcq[i].size();
        return s;
    endfunction

    // One clock cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic cycle(input int pv, input int pr, input logic [NUM_CH-1:0] vmask, input bit rst);
        logic [NUM_CH-1:0]        v, l;
        logic [NUM_CH*DATA_W-1:0] d;
        logic [DATA_W:0]          hd;
        beat_t                    e;
        int                       g;
        bit                       take;
        @(posedge clock);
        #1;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (srcq[i].size() > 0 && bit_of(vmask, i) && $urandom_range(99) < pv) begin
                hd = srcq[i][0];
                v |= NUM_CH'(1) << i;
                l |= NUM_CH'(hd[DATA_W]) << i;
                d |= (NUM_CH*DATA_W)'(hd[DATA_W-1:0]) << (i * DATA_W);
            end
        end
        reset         = rst;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.out_ready = rst ? 1'b0 : ($urandom_range(99) < pr);
        g    = model_grant(v);
        take = (!m_ov || bus.out_ready) && (g >= 0);
        @(negedge clock);
        check("in_ready", 32'(bus.in_ready), take ? (32'd1 << g) : 32'd0);
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (rst) begin
            model_reset();
            expq.delete();
            for (int i = 0; i < NUM_CH; i++) srcq[i].delete();
        end else begin
            if (take) begin
                hd     = srcq[g].pop_front();
                e.data = hd[DATA_W-1:0];
                e.src  = SEL_W'(g);
                e.last = hd[DATA_W];
                expq.push_back(e);
                if (hd[DATA_W]) begin
`ifndef RR_BURST_MUX_FIXED_PRI_EN
                    m_ptr = g;
`endif
                    m_lock = -1;
                end else begin
                    m_lock = g;
                end
            end
            m_ov = take ? 1'b1 : (bus.out_ready ? 1'b0 : m_ov);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (pending() > 0 || expq.size() > 0 || m_ov); t++)
            cycle(100, 100, '1, 1'b0);
        check("drain_sources", 32'(pending()), 32'd0);
        check("drain_scoreboard", 32'(expq.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks holds on stall.
    initial begin : monitor
        beat_t             e;
        logic [DATA_W-1:0] pd;
        logic [SEL_W-1:0]  ps;
        logic              pl;
        bit                pstall;
        pstall = 1'b0;
        pd = '0; ps = '0; pl = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    check("hold_valid", 32'(bus.out_valid), 32'd1);
                    check("hold_data", 32'(bus.out_data), 32'(pd));
                    check("hold_src", 32'(bus.out_src), 32'(ps));
                    check("hold_last", 32'(bus.out_last), 32'(pl));
                end
                if (bus.out_valid && bus.out_ready) begin
                    check("scoreboard_nonempty", 32'(expq.size() > 0), 32'd1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("out_data", 32'(bus.out_data), 32'(e.data));
                        check("out_src", 32'(bus.out_src), 32'(e.src));
                        check("out_last", 32'(bus.out_last), 32'(e.last));
                    end
                end
                pstall = bus.out_valid && !bus.out_ready;
                pd = bus.out_data;
                ps = bus.out_src;
                pl = bus.out_last;
            end
        end
    end

    initial begin : stimulus
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);

        // Single beats on all channels, full throughput.
        for (int n = 0; n < 4; n++) begin
            add_beat(0, 8'h11, 1'b1);
            add_beat(1, 8'h22, 1'b1);
            add_beat(2, 8'h33, 1'b1);
        end
        drain();

        // Ch1 four-beat burst while ch0/ch2 stay valid.
        cycle(100, 100, '1, 1'b1);
        add_beat(0, 8'h01, 1'b1);
        add_burst(1, 4, 8'hA0);
        for (int n = 0; n < 3; n++) begin
            add_beat(0, 8'h05, 1'b1);
            add_beat(2, 8'h02, 1'b1);
        end
        drain();

        // Output stall for three cycles.
        for (int i = 0; i < NUM_CH; i++) add_burst(i, 1, DATA_W'(8'h40 + i));
        for (int i = 0; i < NUM_CH; i++) add_burst(i, 2, DATA_W'(8'h50 + 4 * i));
        cycle(100, 100, '1, 1'b0);
        cycle(100, 100, '1, 1'b0);
        repeat (3) cycle(100, 0, '1, 1'b0);
        drain();

        // Ch0 drops valid mid-burst while ch2 waits.
        cycle(100, 100, '1, 1'b1);
        add_burst(0, 5, 8'hC0);
        for (int n = 0; n < 3; n++) add_beat(2, 8'hE0 + DATA_W'(n), 1'b1);
        cycle(100, 100, '1, 1'b0);
        cycle(100, 100, '1, 1'b0);
        repeat (2) cycle(100, 100, 3'b110, 1'b0);
        drain();

        // Reset while ch2 holds the lock, then all valid: ch0 first.
        cycle(100, 100, '1, 1'b1);
        add_burst(2, 5, 8'h70);
        cycle(100, 100, '1, 1'b0);
        cycle(100, 100, '1, 1'b0);
        cycle(100, 100, '1, 1'b1);
        for (int i = 0; i < NUM_CH; i++) add_beat(i, DATA_W'(8'h90 + i), 1'b1);
        cycle(100, 100, '1, 1'b0);
        cycle(100, 100, '1, 1'b0);
        check("first_src_after_reset", 32'(bus.out_src), 32'd0);
        drain();

        // Randomised traffic: bursts of 1..4 beats, random valid and ready.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (srcq[i].size() < 3 && $urandom_range(99) < 30)
                    add_burst(i, int'($urandom_range(4, 1)), DATA_W'($urandom));
            end
            cycle(75, 70, '1, 1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
